if_id_fetch_queue: RTL and testbench
====================================

Name: if_id_fetch_queue

Overview:
- Instruction queue between the instruction-fetch stage and the decode stage of the 5-stage ARM pipeline.
- Buffers up to DEPTH {PC, instruction} pairs from fetch, so decode stalls need not freeze fetch immediately.
- Its full condition is the fetch stage's freeze source.
- A taken branch flushes all buffered wrong-path instructions.

Parameters:
- WORD_LEN, 32, width of PC and instruction words (matches `ADDR_LEN / `INSTRUCTION_LEN).
- DEPTH, 4, number of entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  pipeline clock; rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  branch taken (from EXE); discards all entries.
- in_valid  in  1  fetch presents a valid instruction.
- in_pc  in  WORD_LEN  PC+4 of the fetched instruction.
- in_instr  in  WORD_LEN  fetched instruction.
- in_ready  out  1  queue can accept; fetch freeze = ~in_ready.
- out_valid  out  1  head entry is valid for decode.
- out_pc  out  WORD_LEN  head PC.
- out_instr  out  WORD_LEN  head instruction.
- out_ready  in  1  decode consumes the head this cycle (~hazard stall).
- count  out  PTR_W+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Storage: circular buffer with wr_ptr and rd_ptr (PTR_W bits, wrap modulo DEPTH) plus a registered count.
- Reset (reset=0, asynchronous):
  - wr_ptr, rd_ptr and count go to 0.
  - All storage words go to 0.
  - Outputs: out_valid=0, out_pc=0, out_instr=0, in_ready=1.
  - Reset asserted mid-operation discards all contents immediately.
- in_ready = (count != DEPTH). It is driven from registered count only; there is no combinational path from out_ready.
- Push: in_valid & in_ready at a clock edge writes mem[wr_ptr] and increments wr_ptr.
- Pop: out_valid & out_ready at a clock edge increments rd_ptr.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged; this is legal at any count < DEPTH, including count=1.
- When full, in_ready=0, so a simultaneous pop does not allow a push that cycle. There is no full-bypass.
- out_valid = (count != 0).
- out_pc and out_instr = mem[rd_ptr] when out_valid=1. When empty they are forced to 0 (decode treats 0 as a bubble).
- Latency: a push at edge N makes the data visible at the outputs after edge N. There is no same-cycle empty bypass.
- flush has priority over push and pop. On an edge with flush=1:
  - wr_ptr, rd_ptr and count go to 0.
  - Any push that cycle is dropped (wrong path).
  - Any pop that cycle is still considered consumed by decode; the queue does not care.
  - Storage is not cleared.
- After a flush, out_valid=0 for at least one cycle. The branch-target instruction appears after the next push.
- Ignored inputs:
  - in_valid=1 while in_ready=0: ignored, no state change. Fetch is frozen and re-presents.
  - out_ready=1 while out_valid=0: ignored, no underflow.
- Pointer wrap: DEPTH-1 → 0 on increment, with no special case. FIFO order is preserved across wrap.
- Invariant: count == (wr_ptr − rd_ptr) mod DEPTH, except when full (count=DEPTH and wr_ptr==rd_ptr).
- All state changes happen on the rising edge of clk, except reset.

Test Plan:
- Reset then fill: assert reset=0 for 2 cycles, release. Push PCs 0x4, 0x8, 0xC, 0x10 with instructions 0xE3A01005..0xE3A01008, out_ready=0.
  - After edge 4: count=4, in_ready=0.
  - out_pc=0x4, out_instr=0xE3A01005.
- Full stall: with the queue full and in_valid=1 (PC 0x14) for 3 cycles, out_ready=0 → count stays 4 and 0x14 is never stored.
  - Then raise out_ready for 1 cycle → count=3, in_ready=1, head PC=0x8.
- Streaming: out_ready=1 continuously while pushing PC 0x4..0x40 (16 words).
  - count stays 1 after the first push.
  - Outputs appear in order, each one cycle after its push.
  - Pointers wrap 4 times with no loss.
- Flush: with count=3 (heads 0x4, 0x8, 0xC), assert flush with in_valid=1, in_pc=0x10.
  - Next cycle: count=0, out_valid=0, out_instr=0.
  - Next push of PC 0x104 (branch target) appears as head after one edge.
- Reset mid-operation: with count=2, pulse reset=0 asynchronously between edges.
  - out_valid drops to 0 before the next clock edge.
  - count=0, in_ready=1.
- Empty pop / simultaneous push-pop at count=1: out_ready=1 with count=0 → no change.
  - At count=1 (head 0x20), push 0x24 with out_ready=1 → count stays 1, head becomes 0x24.

Source files
------------

// File: rtl/if_id_fetch_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {PC, instruction} pairs.
// Full (~in_ready) freezes fetch; a taken branch (flush) discards all buffered entries.
module if_id_fetch_queue #(
  parameter  int WORD_LEN = 32,
  parameter  int DEPTH    = 4,
  localparam int PTR_W    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [WORD_LEN-1:0] in_pc,
  input  logic [WORD_LEN-1:0] in_instr,
  output logic                in_ready,
  output logic                out_valid,
  output logic [WORD_LEN-1:0] out_pc,
  output logic [WORD_LEN-1:0] out_instr,
  input  logic                out_ready,
  output logic [PTR_W:0]      count
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [WORD_LEN-1:0] mem_pc    [DEPTH];
  logic [WORD_LEN-1:0] mem_instr [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic                push;
  logic                pop;

  // in_ready depends only on registered count, never on out_ready.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_pc    = out_valid ? mem_pc[rd_ptr]    : '0;
  assign out_instr = out_valid ? mem_instr[rd_ptr] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage is cleared by reset only; flush just rewinds the pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_pc    <= '{default: '0};
      mem_instr <= '{default: '0};
    end else if (push && !flush) begin
      mem_pc[wr_ptr]    <= in_pc;
      mem_instr[wr_ptr] <= in_instr;
    end
  end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Bench for if_id_fetch_queue: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_if_id_fetch_queue;

  localparam int WORD_LEN = 32;
  localparam int DEPTH    = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                flush = 1'b0;
  logic                in_valid = 1'b0;
  logic [WORD_LEN-1:0] in_pc = '0;
  logic [WORD_LEN-1:0] in_instr = '0;
  logic                in_ready;
  logic                out_valid;
  logic [WORD_LEN-1:0] out_pc;
  logic [WORD_LEN-1:0] out_instr;
  logic                out_ready = 1'b0;
  logic [2:0]          count;

  int checks = 0;
  int errors = 0;

  if_id_fetch_queue #(.WORD_LEN(WORD_LEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t mq[$];

  always @(negedge reset) mq.delete();

  always @(posedge clk) begin
    if (reset) begin
      automatic bit acc = in_valid && (mq.size() < DEPTH);
      automatic bit deq = out_ready && (mq.size() > 0);
      if (flush) mq.delete();
      else begin
        if (deq) void'(mq.pop_front());
        if (acc) mq.push_back('{pc: in_pc, instr: in_instr});
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    automatic int n = mq.size();
    chk("model_count", 32'(count), 32'(n));
    chk("model_in_ready", 32'(in_ready), 32'(n != DEPTH));
    chk("model_out_valid", 32'(out_valid), 32'(n != 0));
    chk("model_out_pc", out_pc, (n != 0) ? mq[0].pc : 32'h0);
    chk("model_out_instr", out_instr, (n != 0) ? mq[0].instr : 32'h0);
  end

  task automatic drive(input logic fl, input logic v, input logic [31:0] pc,
                       input logic [31:0] ins, input logic ordy);
    flush = fl; in_valid = v; in_pc = pc; in_instr = ins; out_ready = ordy;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_instr", out_instr, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 4; i++) drive(0, 1, 32'(4 * (i + 1)), 32'hE3A01005 + 32'(i), 0);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_out_pc", out_pc, 32'h4);
    chk("fill_out_instr", out_instr, 32'hE3A01005);

    for (int i = 0; i < 3; i++) drive(0, 1, 32'h14, 32'hE3A01009, 0);
    chk("stall_count", 32'(count), 32'd4);
    drive(0, 1, 32'h14, 32'hE3A01009, 1);
    chk("stall_pop_count", 32'(count), 32'd3);
    chk("stall_pop_in_ready", 32'(in_ready), 32'd1);
    chk("stall_pop_head", out_pc, 32'h8);
    for (int i = 0; i < 3; i++) drive(0, 0, 32'h0, 32'h0, 1);
    chk("drain_count", 32'(count), 32'd0);

    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 32'(4 * (i + 1)), 32'hE3A02000 + 32'(i), 1);
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_head", out_pc, 32'(4 * (i + 1)));
    end
    drive(0, 0, 32'h0, 32'h0, 1);
    chk("stream_drain", 32'(count), 32'd0);

    drive(0, 1, 32'h4, 32'hE3A03001, 0);
    drive(0, 1, 32'h8, 32'hE3A03002, 0);
    drive(0, 1, 32'hC, 32'hE3A03003, 0);
    chk("preflush_count", 32'(count), 32'd3);
    drive(1, 1, 32'h10, 32'hE3A03004, 1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_out_instr", out_instr, 32'h0);
    drive(0, 1, 32'h104, 32'hEA000010, 0);
    chk("target_head", out_pc, 32'h104);
    chk("target_instr", out_instr, 32'hEA000010);

    drive(0, 1, 32'h200, 32'hE3A04000, 0);
    chk("premid_count", 32'(count), 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b1;

    drive(0, 0, 32'h0, 32'h0, 1);
    chk("empty_pop_count", 32'(count), 32'd0);
    chk("empty_pop_valid", 32'(out_valid), 32'd0);
    drive(0, 1, 32'h20, 32'hE3A05000, 0);
    chk("one_head", out_pc, 32'h20);
    drive(0, 1, 32'h24, 32'hE3A05001, 1);
    chk("pushpop1_count", 32'(count), 32'd1);
    chk("pushpop1_head", out_pc, 32'h24);
    chk("pushpop1_instr", out_instr, 32'hE3A05001);

    repeat (2) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
